smi_request_arbiter_x4: RTL
===========================

Name: smi_request_arbiter_x4

Overview:
Shares one SMI request/response port pair on the AXI bus adaptor between four SMI requesters. The request side arbitrates whole frames round-robin and tags each header flit with the winning port index. The response side uses that tag to steer each response frame back to its originator. Sits between kernel-side SMI clients and the bus adaptor's smiReq*/smiResp* ports.

Parameters:
FlitWidth, 16, flit width in bytes; data buses are FlitWidth*8 bits; minimum 16.
TagLsb, 8, bit position of the 2-bit port tag within the header flit (data[TagLsb+1:TagLsb]).

Ports:
clk  in  1  clock.
rst_n  in  1  reset; asynchronous assert, active-low.
inReqReady  in  4  per-port request flit valid.
inReqEofc  in  4x8  per-port end-of-frame control; 0 = mid-frame, nonzero = last flit.
inReqData  in  4xFlitWidth*8  per-port request flit.
inReqStop  out  4  per-port backpressure.
outReqReady  out  1  request flit valid, to adaptor.
outReqEofc  out  8  request eofc.
outReqData  out  FlitWidth*8  request flit, tag inserted in header.
outReqStop  in  1  adaptor backpressure.
inRespReady  in  1  response flit valid, from adaptor.
inRespEofc  in  8  response eofc.
inRespData  in  FlitWidth*8  response flit.
inRespStop  out  1  backpressure to adaptor.
outRespReady  out  4  per-port response flit valid.
outRespEofc  out  4x8  per-port response eofc.
outRespData  out  4xFlitWidth*8  per-port response flit.
outRespStop  in  4  per-port response backpressure.

Behaviour:
- Handshake on every interface: a flit transfers when Ready=1 and Stop=0 in the same cycle. Data and Eofc are held stable while Ready=1 and Stop=1.
- Reset (rst_n=0, asynchronous): request FSM to IDLE; round-robin pointer to 0; both output registers empty.
  - Outputs during reset: outReqReady=0, outRespReady=0000, inReqStop=1111, inRespStop=0, all Data/Eofc=0.
  - Reset mid-frame discards the partial frame. No recovery of in-flight frames.
- Request FSM, IDLE:
  - Grant to the first port with inReqReady=1, searching from pointer, pointer+1, ... (mod 4).
  - Record the grant; go to HEADER in the same cycle. Nothing is transferred in the arbitration cycle.
- Request FSM, HEADER:
  - Only the granted port has Stop deasserted.
  - On transfer, data[TagLsb+1:TagLsb] is replaced by the grant index.
  - Eofc=0 -> BODY. Eofc!=0 (single-flit frame) -> RELEASE.
- Request FSM, BODY:
  - Pass flits through untouched.
  - Transfer with Eofc!=0 -> RELEASE.
- Request FSM, RELEASE: pointer := grant+1 (mod 4); -> IDLE. No port can win twice in a row while another port is waiting.
- Request output stage: 2-entry buffer. inReqStop is driven from buffer state only, not combinationally from outReqStop.
  - Latency: header accepted at cycle N appears on outReq at N+1 if outReqStop=0.
  - Throughput: 1 flit/cycle within a frame.
  - Per-frame overhead: 2 bubble cycles (RELEASE + IDLE arbitration).
- Ports not granted: inReqStop=1. A requester dropping Ready mid-frame simply stalls the frame; the grant is held.
- Response path, first flit of each frame:
  - Decode port = data[TagLsb+1:TagLsb] and latch it for the rest of the frame.
  - Clear the tag bits to 0 before forwarding.
- Response path, other flits: routed to the latched port untouched. The latch releases after the flit with Eofc!=0.
- Response output stage:
  - One output register; only the selected port's outRespReady=1.
  - inRespStop = register full and the selected port's outRespStop=1.
  - Latency 1 cycle; 1 flit/cycle.
- Request and response paths are independent. Simultaneous request grant and response delivery to the same port is legal.
- Requesters must drive tag bits = 0. Nonzero bits are overwritten.

Test Plan:
- Single requester: port 2 sends a 3-flit frame with header data[9:8]=00 -> outReq carries 3 flits in order, header data[9:8]=10, last Eofc unchanged, first flit one cycle after acceptance.
- Fairness: all 4 ports continuously send 1-flit frames -> grant order 0,1,2,3,0,1 and no port is granted twice while another waits.
- Backpressure: outReqStop=1 for 5 cycles mid-frame -> no flit lost or duplicated, held data stable, buffer ≤2 entries, inReqStop[grant] asserted once the buffer is full.
- Response steering: adaptor returns 2-flit frames tagged 11 then 01 -> port 3 then port 1 receive the frames with tag bits cleared; other ports see Ready=0.
- Response stall: outRespStop[1]=1 during a port-1 frame -> inRespStop=1 until released, then the frame completes intact.
- Async reset asserted mid-frame at a non-clock edge -> outputs reach reset values immediately; after release, port 0 wins first arbitration.

Source files
------------

// File: rtl/smi_request_arbiter_x4.sv
// Four-way SMI port sharer: round-robin whole-frame request arbitration with a port
// tag in each header flit, and tag-steered delivery of response frames.
module smi_request_arbiter_x4 #(
  parameter int FlitWidth = 16,
  parameter int TagLsb    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    inReqReady,
  input  logic [3:0][7:0]               inReqEofc,
  input  logic [3:0][FlitWidth*8-1:0]   inReqData,
  output logic [3:0]                    inReqStop,
  output logic                          outReqReady,
  output logic [7:0]                    outReqEofc,
  output logic [FlitWidth*8-1:0]        outReqData,
  input  logic                          outReqStop,
  input  logic                          inRespReady,
  input  logic [7:0]                    inRespEofc,
  input  logic [FlitWidth*8-1:0]        inRespData,
  output logic                          inRespStop,
  output logic [3:0]                    outRespReady,
  output logic [3:0][7:0]               outRespEofc,
  output logic [3:0][FlitWidth*8-1:0]   outRespData,
  input  logic [3:0]                    outRespStop
);
  localparam int DW = FlitWidth * 8;

  // Handshake on every interface: a flit moves when Ready=1 and Stop=0 in the same
  // cycle; the sender keeps Data/Eofc stable while Ready=1 and Stop=1.

  typedef enum logic [1:0] {REQ_IDLE, REQ_HEADER, REQ_BODY, REQ_RELEASE} req_state_t;

  req_state_t       req_state, req_state_next;
  logic [1:0]       rr_ptr, grant, grant_next;
  logic             arb_hit;
  logic [1:0]       arb_idx;
  logic             req_active, req_full, req_push, req_pop;
  logic [DW-1:0]    push_data;
  logic [7:0]       push_eofc;
  logic [DW+7:0]    fifo_mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       fifo_count;

  // Descending scan so the lowest offset from the pointer wins.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (inReqReady[rr_ptr + 2'(i)]) begin
        arb_hit = 1'b1;
        arb_idx = rr_ptr + 2'(i);
      end
    end
  end

  assign req_active = (req_state == REQ_HEADER) || (req_state == REQ_BODY);
  assign req_full   = (fifo_count == 2'd2);
  assign req_push   = req_active && !req_full && inReqReady[grant];
  assign req_pop    = outReqReady && !outReqStop;

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      inReqStop[p] = !(req_active && !req_full && (grant == 2'(p)));
    end
    push_data = inReqData[grant];
    push_eofc = inReqEofc[grant];
    if (req_state == REQ_HEADER) push_data[TagLsb +: 2] = grant;
  end

  always_comb begin
    req_state_next = req_state;
    grant_next     = grant;
    case (req_state)
      REQ_IDLE: begin
        if (arb_hit) begin
          grant_next     = arb_idx;
          req_state_next = REQ_HEADER;
        end
      end
      REQ_HEADER: begin
        if (req_push) req_state_next = (push_eofc != 8'd0) ? REQ_RELEASE : REQ_BODY;
      end
      REQ_BODY: begin
        if (req_push && (push_eofc != 8'd0)) req_state_next = REQ_RELEASE;
      end
      default: req_state_next = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_state <= REQ_IDLE;
      grant     <= 2'd0;
      rr_ptr    <= 2'd0;
    end else begin
      req_state <= req_state_next;
      grant     <= grant_next;
      if (req_state == REQ_RELEASE) rr_ptr <= grant + 2'd1;
    end
  end

  // Two entries let the input keep streaming for one cycle after the adaptor stops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (req_push) begin
        fifo_mem[wr_ptr] <= {push_eofc, push_data};
        wr_ptr           <= !wr_ptr;
      end
      if (req_pop) rd_ptr <= !rd_ptr;
      case ({req_push, req_pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign outReqReady = (fifo_count != 2'd0);
  assign {outReqEofc, outReqData} = outReqReady ? fifo_mem[rd_ptr] : '0;

  logic          resp_valid, resp_in_frame, resp_accept;
  logic [1:0]    resp_port, resp_frame_port, route_port;
  logic [DW-1:0] resp_data, route_data;
  logic [7:0]    resp_eofc;

  assign inRespStop  = resp_valid && outRespStop[resp_port];
  assign resp_accept = inRespReady && !inRespStop;

  // The first flit of a frame carries the destination; later flits follow the latch.
  always_comb begin
    route_port = resp_in_frame ? resp_frame_port : inRespData[TagLsb +: 2];
    route_data = inRespData;
    if (!resp_in_frame) route_data[TagLsb +: 2] = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid      <= 1'b0;
      resp_port       <= 2'd0;
      resp_data       <= '0;
      resp_eofc       <= 8'd0;
      resp_in_frame   <= 1'b0;
      resp_frame_port <= 2'd0;
    end else if (resp_accept) begin
      resp_valid      <= 1'b1;
      resp_port       <= route_port;
      resp_data       <= route_data;
      resp_eofc       <= inRespEofc;
      resp_in_frame   <= (inRespEofc == 8'd0);
      resp_frame_port <= route_port;
    end else if (resp_valid && !outRespStop[resp_port]) begin
      resp_valid <= 1'b0;
    end
  end

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      outRespReady[p] = resp_valid && (resp_port == 2'(p));
      outRespEofc[p]  = (resp_valid && (resp_port == 2'(p))) ? resp_eofc : 8'd0;
      outRespData[p]  = (resp_valid && (resp_port == 2'(p))) ? resp_data : '0;
    end
  end

endmodule
